// File: rtl/split_n_pkg.sv
// ============================================================================
// Module : split_pkg
// Brief  : Shared constants, pointer-width helper and mask type for split_n.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package split_pkg;

  localparam int DEF_WIDTH   = 11;
  localparam int DEF_NUM_OUT = 4;
  localparam int DEF_DEPTH   = 2;
  localparam int DEF_CNT_W   = 16;

  typedef logic [DEF_NUM_OUT-1:0] mask_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/split_n_if.sv
// ============================================================================
// Module : split_n_if
// Brief  : Data/control join inputs and per-output channels of split_n.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface split_n_if #(
  parameter int WIDTH   = 11,
  parameter int NUM_OUT = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_data;
  logic                     ctrl_valid;
  logic                     ctrl_ready;
  logic [NUM_OUT-1:0]       ctrl_mask;
  logic [NUM_OUT-1:0]       out_valid;
  logic [NUM_OUT-1:0]       out_ready;
  logic [NUM_OUT*WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, ctrl_valid, ctrl_mask, out_ready,
    output in_ready, ctrl_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, ctrl_valid, ctrl_mask, out_ready,
    input  in_ready, ctrl_ready, out_valid, out_data
  );
endinterface

`default_nettype wire

// File: rtl/split_n_fifo.sv
// ============================================================================
// Module : split_n_fifo
// Brief  : One per-output FIFO; a push is honoured only while space remains.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module split_n_fifo
  import split_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int DEPTH = 2
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] push_data,
  output logic                  has_space,
  input  wire logic             pop,
  output logic                  valid,
  output logic [WIDTH-1:0]      head_data
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW:0] C_DEPTH = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [PW:0]      cnt_q, cnt_d;
  logic             w_push, w_pop;

  assign has_space = (cnt_q < C_DEPTH);
  assign valid     = (cnt_q != '0);
  assign head_data = mem_q[rd_q];
  // full FIFO blocks the push even if a pop happens this cycle
  assign w_push    = push & has_space;
  assign w_pop     = pop & valid;

  always_comb begin
    cnt_d = cnt_q;
    if (w_push && !w_pop)      cnt_d = cnt_q + 1'b1;
    else if (w_pop && !w_push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (w_push) wr_q <= wr_q + 1'b1;
      if (w_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_q] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/split_n.sv
// ============================================================================
// Module : split_n
// Brief  : Joins a data and a mask token, atomically multicasts into per-output FIFOs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module split_n
  import split_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  wire logic       clk,
  input  wire logic       reset,
  split_n_if.slave        bus,
  output logic [CNT_W-1:0] drop_count
);

  logic [NUM_OUT-1:0] w_space;
  logic [NUM_OUT-1:0] w_push;
  logic               w_space_ok;
  logic               w_fire;
  logic [CNT_W-1:0]   drop_q, drop_d;

  // space is judged on registered counts only, keeping in_ready off out_ready
  assign w_space_ok = ~|(bus.ctrl_mask & ~w_space);
  assign w_fire     = bus.in_valid & bus.ctrl_valid & ~reset & w_space_ok;
  assign w_push     = {NUM_OUT{w_fire}} & bus.ctrl_mask;

  assign bus.in_ready   = w_fire;
  assign bus.ctrl_ready = w_fire;
  assign drop_count     = drop_q;

  generate
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out
      split_n_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push[gi]),
        .push_data (bus.in_data),
        .has_space (w_space[gi]),
        .pop       (bus.out_ready[gi]),
        .valid     (bus.out_valid[gi]),
        .head_data (bus.out_data[gi*WIDTH +: WIDTH])
      );
    end
  endgenerate

  always_comb begin
    drop_d = drop_q;
    if (w_fire && (bus.ctrl_mask == '0) && (drop_q != '1))
      drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

endmodule

`default_nettype wire

// File: tb/tb_split_n.sv
// ============================================================================
// Module : tb_split_n
// Brief  : Directed and random checks of split_n against a queue-based model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_split_n;

  localparam int WIDTH   = 11;
  localparam int NUM_OUT = 4;
  localparam int DEPTH   = 2;
  localparam int CNT_W   = 2;

  logic             clk;
  logic             reset;
  logic [CNT_W-1:0] drop_count;

  split_n_if #(.WIDTH(WIDTH), .NUM_OUT(NUM_OUT)) bus ();

  split_n #(
    .WIDTH   (WIDTH),
    .NUM_OUT (NUM_OUT),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] mq [NUM_OUT][$];
  int               drop_m = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_space(input logic [NUM_OUT-1:0] m);
    for (int i = 0; i < NUM_OUT; i++)
      if (m[i] && mq[i].size() >= DEPTH) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NUM_OUT; i++) mq[i].delete();
    drop_m = 0;
  endtask

  task automatic drive(input bit iv, input bit cv, input logic [NUM_OUT-1:0] m,
                       input logic [WIDTH-1:0] d, input logic [NUM_OUT-1:0] ordy);
    bus.in_valid   = iv;
    bus.ctrl_valid = cv;
    bus.ctrl_mask  = m;
    bus.in_data    = d;
    bus.out_ready  = ordy;
  endtask

  // called at a falling edge with inputs already driven; returns at the next falling edge
  task automatic step(input string tag);
    bit               exp_fire;
    logic [NUM_OUT-1:0] m;
    logic [WIDTH-1:0]   d;
    logic [NUM_OUT-1:0] ordy;
    #1;
    m    = bus.ctrl_mask;
    d    = bus.in_data;
    ordy = bus.out_ready;
    exp_fire = bus.in_valid && bus.ctrl_valid && model_space(m);
    chk({tag, ".in_ready"},   64'(bus.in_ready),   64'(exp_fire));
    chk({tag, ".ctrl_ready"}, 64'(bus.ctrl_ready), 64'(exp_fire));
    chk({tag, ".drop"},       64'(drop_count),     64'(drop_m));
    for (int i = 0; i < NUM_OUT; i++) begin
      chk($sformatf("%s.out_valid[%0d]", tag, i), 64'(bus.out_valid[i]), 64'(mq[i].size() != 0));
      if (mq[i].size() != 0)
        chk($sformatf("%s.out_data[%0d]", tag, i), 64'(bus.out_data[i*WIDTH +: WIDTH]), 64'(mq[i][0]));
    end
    @(posedge clk);
    for (int i = 0; i < NUM_OUT; i++)
      if (ordy[i] && mq[i].size() != 0) void'(mq[i].pop_front());
    if (exp_fire) begin
      if (m == '0) begin
        if (drop_m < (1 << CNT_W) - 1) drop_m++;
      end else begin
        for (int i = 0; i < NUM_OUT; i++)
          if (m[i]) mq[i].push_back(d);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    drive(1'b1, 1'b1, 4'b0001, 11'h0A5, 4'b1111);
    reset = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    chk("rst.out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst.in_ready",  64'(bus.in_ready),  64'(0));
    chk("rst.ctrl_ready",64'(bus.ctrl_ready),64'(0));
    chk("rst.drop",      64'(drop_count),    64'(0));
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 4'b1111);
    step("idle");

    // unicast sweep
    for (int i = 0; i < NUM_OUT; i++) begin
      drive(1'b1, 1'b1, 4'(1 << i), 11'h0A5, 4'b1111);
      step($sformatf("uni%0d", i));
      drive(1'b0, 1'b0, '0, '0, 4'b1111);
      step($sformatf("uni%0d_out", i));
    end

    // join skew: data waits for control
    drive(1'b1, 1'b0, 4'b0100, 11'h123, 4'b1111);
    repeat (3) step("skew_wait");
    drive(1'b1, 1'b1, 4'b0100, 11'h123, 4'b1111);
    step("skew_fire");
    drive(1'b0, 1'b0, '0, '0, 4'b1111);
    step("skew_out");

    // multicast blocked by output 2 while output 1 drains
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 4'b0110, 11'(11'h300 + k), 4'b1011);
      step($sformatf("mc%0d", k));
    end
    chk("mc.stall_in_ready", 64'(bus.in_ready), 64'(0));
    chk("mc.out1_empty",     64'(bus.out_valid[1]), 64'(0));
    drive(1'b1, 1'b1, 4'b0110, 11'h302, 4'b1111);
    step("mc_release");
    drive(1'b0, 1'b0, '0, '0, 4'b1111);
    repeat (3) step("mc_drain");

    // head-of-line isolation
    drive(1'b0, 1'b0, '0, '0, 4'b1110);
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 4'b0001, 11'(11'h040 + k), 4'b1110);
      step("hol_fill");
    end
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1, 4'b0010, 11'(11'h050 + k), 4'b1110);
      step("hol_stream");
    end
    drive(1'b0, 1'b0, '0, '0, 4'b1111);
    repeat (3) step("hol_drain");

    // zero mask with saturating drop counter
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 4'b0000, 11'(k), 4'b1111);
      step("zero");
    end
    drive(1'b0, 1'b0, '0, '0, 4'b1111);
    step("zero_idle");
    chk("zero.drop_sat", 64'(drop_count), 64'(3));

    // asynchronous reset with two full FIFOs
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b1, 4'b0011, 11'(11'h070 + k), 4'b0000);
      step("ar_fill");
    end
    drive(1'b1, 1'b1, 4'b0011, 11'h07F, 4'b0000);
    step("ar_stall");
    #2;
    reset = 1'b1;
    #1;
    chk("ar.out_valid", 64'(bus.out_valid), 64'(0));
    chk("ar.in_ready",  64'(bus.in_ready),  64'(0));
    chk("ar.drop",      64'(drop_count),    64'(0));
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 1'b1, 4'b0010, 11'h1EE, 4'b1111);
    step("ar_post");
    drive(1'b0, 1'b0, '0, '0, 4'b1111);
    step("ar_post_out");

    // random traffic
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
            4'($urandom), 11'($urandom), 4'($urandom));
      step("rnd");
    end
    drive(1'b0, 1'b0, '0, '0, 4'b1111);
    repeat (4) step("rnd_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/split_n.md
Name: split_n

Overview:
- Clocked, parametrised successor to the 4-way channel split.
- Joins one data token with one destination-control token, then delivers the data to one or more of NUM_OUT output channels.
- Each output has its own FIFO, so one stalled consumer does not block tokens addressed to the other outputs.
- Sits at router output-select points in the NoC, between the routing-decision logic and the per-direction link buffers.

Parameters:
- WIDTH, 11: data token width in bits.
- NUM_OUT, 4: number of output channels (2..16).
- DEPTH, 2: entries per output FIFO (power of 2, >=2).
- CNT_W, 16: width of the dropped-token counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  reset, asynchronous, active-high.
- in_valid  in  1  data token present.
- in_ready  out  1  data token consumed this cycle.
- in_data  in  WIDTH  data token.
- ctrl_valid  in  1  control token present.
- ctrl_ready  out  1  control token consumed this cycle.
- ctrl_mask  in  NUM_OUT  destination mask; bit i selects output i; multiple bits set = multicast.
- out_valid  out  NUM_OUT  per-output token present.
- out_ready  in  NUM_OUT  per-output consumer accepts.
- out_data  out  NUM_OUT*WIDTH  packed; output i occupies bits [i*WIDTH +: WIDTH].
- drop_count  out  CNT_W  number of tokens received with an all-zero mask.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. While reset is high:
  - all FIFOs empty;
  - out_valid = 0;
  - drop_count = 0;
  - in_ready = ctrl_ready = 0.
- Join (replaces the fork/join receive of the 4-way split):
  - fire = in_valid & ctrl_valid & ~reset & space_ok.
  - space_ok = for every i with ctrl_mask[i]=1, count[i] < DEPTH.
  - in_ready = ctrl_ready = fire. Both tokens are always consumed in the same cycle; a lone data or lone control token is never consumed.
- Atomic multicast:
  - On fire, in_data is pushed into every selected FIFO in the same cycle.
  - If any selected FIFO is full, nothing is pushed and neither input is consumed. There is no partial delivery.
- Zero mask:
  - fire still occurs (space_ok is trivially true), and the token is discarded.
  - drop_count increments by 1 and saturates at 2^CNT_W-1.
- Output channel i:
  - out_valid[i] = (count[i] != 0).
  - out_data slice i = FIFO head.
  - Pop occurs when out_valid[i] & out_ready[i].
- Latency:
  - A token accepted at edge t is visible on out_valid/out_data at t+1.
  - There is no combinational in->out path.
  - Throughput is 1 token/cycle per output when unblocked.
- Ready path: space_ok uses the registered count only, so in_ready never depends combinationally on out_ready.
- Push and pop on the same FIFO in the same cycle:
  - Legal when count < DEPTH; count is unchanged and order is preserved.
  - When full, the push is blocked this cycle (no same-cycle pass-through).
- Pointers and counts:
  - Read/write pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Ordering: per-output FIFO order equals acceptance order. There is no ordering guarantee across outputs.
- Reset mid-operation: all buffered tokens are lost, out_valid drops in the same cycle (asynchronous), and operation resumes on the first edge after reset deasserts.
- X-safety: ctrl_mask and in_data are ignored unless both valids are high.

Decomposition:
- Package split_pkg holds:
  - the default WIDTH/NUM_OUT/DEPTH/CNT_W constants;
  - a function for clog2 pointer widths;
  - typedef mask_t (logic [NUM_OUT-1:0]).
- Sub-module split_n_fifo holds one output buffer:
  - ports: push, push_data, has_space, pop, valid, head_data;
  - parameters WIDTH, DEPTH;
  - split_n instantiates it NUM_OUT times in a generate loop.

Test Plan:
1. Unicast sweep (NUM_OUT=4, DEPTH=2): send data 0x0A5 with mask 0001, 0010, 0100, 1000, all out_ready=1 -> each token appears only on the matching output, exactly 1 cycle after fire; drop_count=0.
2. Join skew: assert in_valid 3 cycles before ctrl_valid -> in_ready=ctrl_ready=0 until ctrl_valid rises; both tokens consumed in the same cycle; single delivery.
3. Multicast blocking: hold out_ready[2]=0, send 3 tokens with mask 0110 -> first two pushed to outputs 1 and 2; third stalls (in_ready=0) even though output 1 is empty; releasing out_ready[2] delivers token 3 to both outputs.
4. Head-of-line isolation: fill output 0 (out_ready[0]=0), then send mask 0010 tokens -> output 1 streams 1 token/cycle, unaffected.
5. Zero mask and saturation: CNT_W=2, send 5 tokens with mask 0000 -> all consumed, no out_valid, drop_count=3 (saturated).
6. Async reset mid-stream: assert reset between edges with both FIFOs full -> out_valid=0 and in_ready=0 immediately; after release, FIFOs are empty and the next token is delivered with 1-cycle latency.
